// File: rtl/ni_flit_injector.sv
// ni_flit_injector: NoC injection stage turning packet requests and payload words into credit-gated flits.
// Optional NI_PKT_STATS_EN adds sent_pkt_cnt/stall_cnt statistics ports.
module ni_flit_injector #(
    parameter int V = 2,
    parameter int B = 4,
    parameter int Fpay = 32,
    parameter int DSTw = 8,
    parameter int LENw = 4,
    localparam int Fw = 2 + V + Fpay,
    localparam int Vw = (V > 1) ? $clog2(V) : 1,
    localparam int Cw = $clog2(B + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [Vw-1:0]   req_vc,
    input  logic [DSTw-1:0] req_dest,
    input  logic [LENw-1:0] req_len,
    input  logic            dat_valid,
    output logic            dat_ready,
    input  logic [Fpay-1:0] dat_payload,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_we,
    input  logic [V-1:0]    credit_in,
`ifdef NI_PKT_STATS_EN
    output logic [31:0]     sent_pkt_cnt,
    output logic [31:0]     stall_cnt,
`endif
    output logic [V-1:0]    credit_avail
);
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t state, state_nxt;
    logic [Vw-1:0] vc_q;
    logic [DSTw-1:0] dest_q;
    logic [LENw-1:0] len_q, rem;
    logic [V-1:0][Cw-1:0] cred, cred_nxt;
    logic [V-1:0] dec_v, inc_v, vc_oh;
    logic cred_ok, issue, tail;
    logic [Fw-1:0] flit_nxt;

    always_comb begin
        vc_oh = V'(1) << vc_q;
        cred_ok = cred[vc_q] != '0;
        req_ready = state == IDLE;
        dat_ready = state == BODY && cred_ok;
        issue = (state == HEAD && cred_ok) || (dat_ready && dat_valid);
        tail = (state == HEAD) ? len_q == '0 : rem == LENw'(1);
        flit_nxt = {state == HEAD, tail, vc_oh, (state == HEAD) ? Fpay'({dest_q, len_q}) : dat_payload};
        state_nxt = (state == IDLE) ? (req_valid ? HEAD : IDLE) : (issue ? (tail ? IDLE : BODY) : state);
    end

    // A return that coincides with an issue is legal even at B; only a true overflow saturates.
    always_comb begin
        dec_v = '0;
        inc_v = '0;
        cred_nxt = cred;
        credit_avail = '0;
        for (int i = 0; i < V; i++) begin
            dec_v[i] = issue && vc_q == Vw'(i);
            inc_v[i] = credit_in[i] && (cred[i] != Cw'(B) || dec_v[i]);
            cred_nxt[i] = cred[i] + Cw'(inc_v[i]) - Cw'(dec_v[i]);
            credit_avail[i] = cred[i] != '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            vc_q <= '0;
            dest_q <= '0;
            len_q <= '0;
            rem <= '0;
            cred <= {V{Cw'(B)}};
            flit_out <= '0;
            flit_out_we <= 1'b0;
        end else begin
            state <= state_nxt;
            cred <= cred_nxt;
            flit_out_we <= issue;
            if (issue) flit_out <= flit_nxt;
            if (issue) rem <= (state == HEAD) ? len_q : rem - LENw'(1);
            if (state == IDLE && req_valid) begin
                vc_q <= req_vc;
                dest_q <= req_dest;
                len_q <= req_len;
            end
`ifndef SYNTHESIS
            for (int i = 0; i < V; i++)
                if (credit_in[i] && cred[i] == Cw'(B) && !dec_v[i])
                    $error("credit overflow on vc %0d", i);
`endif
        end
    end

`ifdef NI_PKT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_pkt_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue && tail) sent_pkt_cnt <= sent_pkt_cnt + 32'd1;
            if (state != IDLE && !cred_ok) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: randomized bench with a packet-level flit model and scenario tasks.
module tb_ni_flit_injector;
    localparam int V = 2, B = 4, Fpay = 32, DSTw = 8, LENw = 4, Fw = 36, Vw = 1;

    typedef struct packed {
        logic [Vw-1:0] vc;
        logic [7:0] dest;
        logic [3:0] len;
    } req_t;

    logic clk = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, dat_valid = 1'b0, req_ready, dat_ready, flit_out_we;
    logic [Vw-1:0] req_vc = '0;
    logic [DSTw-1:0] req_dest = '0;
    logic [LENw-1:0] req_len = '0;
    logic [Fpay-1:0] dat_payload = '0;
    logic [Fw-1:0] flit_out;
    logic [V-1:0] credit_in = '0, credit_avail, man_cred = '0;
`ifdef NI_PKT_STATS_EN
    logic [31:0] sent_pkt_cnt, stall_cnt;
`endif

    ni_flit_injector #(.V(V), .B(B), .Fpay(Fpay), .DSTw(DSTw), .LENw(LENw)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vc(req_vc), .req_dest(req_dest), .req_len(req_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_payload(dat_payload),
        .flit_out(flit_out), .flit_out_we(flit_out_we), .credit_in(credit_in),
`ifdef NI_PKT_STATS_EN
        .sent_pkt_cnt(sent_pkt_cnt), .stall_cnt(stall_cnt),
`endif
        .credit_avail(credit_avail)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, vpct = 100;
    bit auto_ret = 1'b0;
    req_t rq[$];
    logic [31:0] pq[$];
    logic [Fw-1:0] exp_q[$], got[$];
    int got_cyc[$];
    req_t drv_r;
    logic [31:0] drv_w;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, credit returner and request/payload driver; expected flits are built per accepted request.
    always @(negedge clk) begin
        if (reset && flit_out_we) begin
            got.push_back(flit_out);
            got_cyc.push_back(cyc);
        end
        credit_in = (auto_ret && flit_out_we) ? flit_out[Fpay+:V] : man_cred;
        man_cred = '0;
        req_valid = rq.size() > 0;
        if (req_valid) {req_vc, req_dest, req_len} = rq[0];
        dat_valid = pq.size() > 0 && $urandom_range(99) < vpct;
        dat_payload = (pq.size() > 0) ? pq[0] : $urandom;
        #1;
        if (req_valid && req_ready) begin
            drv_r = rq.pop_front();
            exp_q.push_back({1'b1, drv_r.len == 4'd0, V'(1) << drv_r.vc, (32'(drv_r.dest) << 4) + 32'(drv_r.len)});
            for (int i = 1; i <= int'(drv_r.len); i++) begin
                drv_w = $urandom;
                pq.push_back(drv_w);
                exp_q.push_back({1'b0, i == int'(drv_r.len), V'(1) << drv_r.vc, drv_w});
            end
        end
        if (dat_valid && dat_ready) void'(pq.pop_front());
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic give_cred(input logic [V-1:0] m, input int n);
        repeat (n) begin man_cred = m; @(negedge clk); #2; end
    endtask

    task automatic wait_flits(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (got.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk); #2;
        end
    endtask

    task automatic clear_obs();
        got.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if (flit_out_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b want 0", flit_out_we); end
        checks++; if (flit_out !== '0) begin failures++; $display("FAIL rst_flit got %h want 0", flit_out); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (dat_ready !== 1'b0) begin failures++; $display("FAIL rst_dat_ready got %b want 0", dat_ready); end
        checks++; if (credit_avail !== 2'b11) begin failures++; $display("FAIL rst_avail got %b want 11", credit_avail); end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_head_only();
        bit ok;
        auto_ret = 1'b0; vpct = 100; clear_obs();
        rq.push_back({1'b1, 8'h2A, 4'h0});
        wait_flits(1, ok);
        idle(2);
        checks++; if (!ok) begin failures++; $display("FAIL head_timeout got 0 flits want 1"); end
        checks++; if (got.size() != 1) begin failures++; $display("FAIL head_count got %0d want 1", got.size()); end
        checks++; if (got[0] !== 36'hE_0000_02A0) begin failures++; $display("FAIL head_flit got %h want E000002A0", got[0]); end
        checks++; if (credit_avail !== 2'b11) begin failures++; $display("FAIL head_avail got %b want 11", credit_avail); end
    endtask

    task automatic test_body3();
        bit ok;
        clear_obs();
        rq.push_back({1'b0, 8'($urandom), 4'd3});
        wait_flits(4, ok);
        idle(2);
        checks++; if (got.size() != 4) begin failures++; $display("FAIL b3_count got %0d want 4", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL b3_flit%0d got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (ok && got_cyc[3] - got_cyc[0] != 3) begin failures++; $display("FAIL b3_span got %0d want 3", got_cyc[3] - got_cyc[0]); end
        checks++; if (credit_avail !== 2'b10) begin failures++; $display("FAIL b3_avail got %b want 10", credit_avail); end
        give_cred(2'b01, 4);
        idle(1);
        checks++; if (credit_avail !== 2'b11) begin failures++; $display("FAIL b3_restore got %b want 11", credit_avail); end
    endtask

    task automatic test_credit_stall();
        bit ok;
        clear_obs();
        rq.push_back({1'b0, 8'($urandom), 4'd5});
        wait_flits(4, ok);
        idle(4);
        checks++; if (got.size() != 4) begin failures++; $display("FAIL st_count got %0d want 4", got.size()); end
        checks++; if (dat_ready !== 1'b0) begin failures++; $display("FAIL st_dat_ready got %b want 0", dat_ready); end
        give_cred(2'b10, 1);
        idle(2);
        checks++; if (got.size() != 4 || credit_avail !== 2'b10) begin failures++; $display("FAIL st_other_vc got %0d/%b want 4/10", got.size(), credit_avail); end
        give_cred(2'b01, 1);
        idle(1);
        checks++; if (credit_avail[0] !== 1'b1 || got.size() != 4) begin failures++; $display("FAIL st_one_cred got %b/%0d want 1/4", credit_avail[0], got.size()); end
        idle(1);
        checks++; if (credit_avail[0] !== 1'b0 || got.size() != 5) begin failures++; $display("FAIL st_one_more got %b/%0d want 0/5", credit_avail[0], got.size()); end
        give_cred(2'b01, 1);
        wait_flits(6, ok);
        idle(2);
        checks++; if (got.size() != 6) begin failures++; $display("FAIL st_total got %0d want 6", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL st_flit%0d got %h want %h", i, got[i], exp_q[i]); end
        end
        give_cred(2'b01, 4);
        idle(1);
    endtask

    task automatic test_simultaneous();
        bit ok;
        auto_ret = 1'b1; clear_obs();
        rq.push_back({1'b0, 8'($urandom), 4'd7});
        wait_flits(8, ok);
        idle(3);
        auto_ret = 1'b0;
        checks++; if (got.size() != 8) begin failures++; $display("FAIL sim_count got %0d want 8", got.size()); end
        checks++; if (ok && got_cyc[7] - got_cyc[0] != 7) begin failures++; $display("FAIL sim_span got %0d want 7", got_cyc[7] - got_cyc[0]); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL sim_flit%0d got %h want %h", i, got[i], exp_q[i]); end
        end
        clear_obs();
        rq.push_back({1'b0, 8'($urandom), 4'd5});
        wait_flits(4, ok);
        idle(4);
        checks++; if (got.size() != 4 || credit_avail !== 2'b10) begin failures++; $display("FAIL sim_cred_left got %0d/%b want 4/10", got.size(), credit_avail); end
        give_cred(2'b01, 2);
        wait_flits(6, ok);
        idle(2);
        give_cred(2'b01, 4);
        idle(1);
        checks++; if (credit_avail !== 2'b11) begin failures++; $display("FAIL sim_restore got %b want 11", credit_avail); end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        auto_ret = 1'b1; vpct = 60; clear_obs();
        rq.push_back({1'b0, 8'hFF, 4'hF});
        for (int i = 0; i < 12; i++) rq.push_back({1'($urandom), 8'($urandom), 4'($urandom)});
        for (int i = 0; i < 3000 && !done; i++) begin
            done = rq.size() == 0 && pq.size() == 0 && got.size() == exp_q.size();
            if (!done) begin @(negedge clk); #2; end
        end
        idle(3);
        auto_ret = 1'b0; vpct = 100;
        checks++; if (!done) begin failures++; $display("FAIL rnd_timeout got %0d flits want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_flit%0d got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (credit_avail !== 2'b11) begin failures++; $display("FAIL rnd_avail got %b want 11", credit_avail); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        rq.push_back({1'b0, 8'($urandom), 4'd4});
        wait_flits(2, ok);
        reset = 1'b0;
        #1;
        checks++; if (flit_out_we !== 1'b0 || flit_out !== '0) begin failures++; $display("FAIL rm_out got %b/%h want 0/0", flit_out_we, flit_out); end
        checks++; if (req_ready !== 1'b1 || dat_ready !== 1'b0) begin failures++; $display("FAIL rm_ready got %b%b want 10", req_ready, dat_ready); end
        checks++; if (credit_avail !== 2'b11) begin failures++; $display("FAIL rm_avail got %b want 11", credit_avail); end
        rq.delete(); pq.delete(); clear_obs();
        idle(1);
        reset = 1'b1;
        idle(3);
        checks++; if (got.size() != 0) begin failures++; $display("FAIL rm_no_tail got %0d want 0", got.size()); end
        rq.push_back({1'b0, 8'h5C, 4'h0});
        wait_flits(1, ok);
        checks++; if (got[0] !== 36'hD_0000_05C0) begin failures++; $display("FAIL rm_fresh got %h want D000005C0", got[0]); end
        give_cred(2'b01, 1);
        idle(1);
    endtask

`ifdef NI_PKT_STATS_EN
    task automatic test_stats();
        bit ok;
        logic [31:0] s0, t0;
        s0 = sent_pkt_cnt; t0 = stall_cnt; clear_obs();
        rq.push_back({1'b0, 8'($urandom), 4'd4});
        rq.push_back({1'b1, 8'($urandom), 4'd0});
        wait_flits(4, ok);
        give_cred(2'b01, 1);
        wait_flits(6, ok);
        idle(2);
        checks++; if (sent_pkt_cnt - s0 !== 32'd2) begin failures++; $display("FAIL stats_sent got %0d want 2", sent_pkt_cnt - s0); end
        checks++; if (stall_cnt - t0 !== 32'd2) begin failures++; $display("FAIL stats_stall got %0d want 2", stall_cnt - t0); end
        give_cred(2'b01, 4);
        give_cred(2'b10, 1);
        idle(1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_head_only();
        test_body3();
        test_credit_stall();
        test_simultaneous();
        test_random();
        test_reset_mid();
`ifdef NI_PKT_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
